// File: rtl/pll_ctrl.sv
// pll_ctrl: safe divider reconfiguration and lock sequencing
// for the ABPLSSCH PLL, clocked from the PLL reference clock.
module pll_ctrl #(
    parameter int SW_CYC     = 4,
    parameter int STBY_CYC   = 8,
    parameter int LOCK_TMO   = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       cfg_req,
    input  logic       cfg_m,
    input  logic [3:0] cfg_n,
    input  logic [3:0] cfg_pa,
    input  logic [3:0] cfg_pb,
    input  logic [3:0] cfg_pc,
    input  logic       cfg_pben,
    input  logic       cfg_pcen,
    output logic       cfg_ack,
    output logic       pll_stby,
    output logic       pll_pbstby,
    output logic       pll_pcstby,
    output logic       pll_m,
    output logic [3:0] pll_n,
    output logic [3:0] pll_pa,
    output logic [3:0] pll_pb,
    output logic [3:0] pll_pc,
    input  logic       pll_lock,
    output logic       clk_sel,
    output logic       ready,
    output logic       err,
    output logic       lost_lock,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_BYP  = 3'd1,
        S_STBY = 3'd2,
        S_WAIT = 3'd3,
        S_SETL = 3'd4,
        S_ON   = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam int CMAX = (SW_CYC > STBY_CYC) ? SW_CYC : STBY_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(LOCK_TMO + 1);
    localparam int STW  = $clog2(SETTLE_CYC + 1);
    localparam int RW   = $clog2(RETRY + 1);

    localparam logic [CW-1:0]  SW_LAST   = CW'(SW_CYC - 1);
    localparam logic [CW-1:0]  STBY_LAST = CW'(STBY_CYC - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TMO - 1);
    localparam logic [STW-1:0] STL_LAST  = STW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0]  RTY_MAX   = RW'(RETRY);

    state_t         cur, nxt;
    logic [CW-1:0]  cnt, cnt_n;
    logic [TW-1:0]  tmo, tmo_n;
    logic [STW-1:0] stl, stl_n;
    logic [RW-1:0]  rty, rty_n;
    logic           host, host_n;
    logic           accept, lock_loss;
    logic           sync1, lock_s;
    logic           sh_m, sh_pben, sh_pcen;
    logic [3:0]     sh_n, sh_pa, sh_pb, sh_pc;
    logic           stby_n, pbstby_n, pcstby_n;
    logic           sel_n, ack_n, err_n, lost_n, load_div;

    assign state = cur;

    // Two-flop synchronizer for the asynchronous PLOCK pin
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    // Next state, counters and next values of the registered outputs
    always_comb begin
        nxt       = cur;
        cnt_n     = cnt;
        tmo_n     = tmo;
        stl_n     = stl;
        rty_n     = rty;
        host_n    = host;
        accept    = 1'b0;
        lock_loss = 1'b0;
        unique case (cur)
            S_OFF, S_ERR: accept = cfg_req;
            S_BYP: begin
                if (cnt == SW_LAST) begin
                    nxt   = S_STBY;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STBY: begin
                tmo_n = '0;
                if (cnt == STBY_LAST) begin
                    nxt   = S_WAIT;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    // this sampled lock is the first of the settle run
                    nxt   = S_SETL;
                    stl_n = STW'(1);
                end else if (tmo == TMO_LAST) begin
                    tmo_n = '0;
                    if (rty < RTY_MAX) begin
                        rty_n = rty + 1'b1;
                        nxt   = S_STBY;
                    end else begin
                        nxt = S_ERR;
                    end
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_SETL: begin
                if (!lock_s) begin
                    nxt   = S_WAIT;
                    stl_n = '0;
                end else if (stl == STL_LAST) begin
                    nxt   = S_ON;
                    stl_n = '0;
                end else begin
                    stl_n = stl + 1'b1;
                end
            end
            S_ON: begin
                lock_loss = ~lock_s;
                accept    = lock_s & cfg_req;
                if (lock_loss) begin
                    nxt    = S_STBY;
                    rty_n  = '0;
                    host_n = 1'b0;
                end
            end
            default: nxt = S_OFF;
        endcase
        if (accept) begin
            nxt    = S_BYP;
            cnt_n  = '0;
            tmo_n  = '0;
            stl_n  = '0;
            rty_n  = '0;
            host_n = 1'b1;
        end

        stby_n   = pll_stby;
        pbstby_n = pll_pbstby;
        pcstby_n = pll_pcstby;
        err_n    = err;
        lost_n   = lost_lock;
        load_div = (nxt == S_STBY);
        sel_n    = (nxt == S_ON);
        ack_n    = ((nxt == S_ON) && (cur == S_SETL) && host)
                || ((nxt == S_ERR) && (cur != S_ERR));
        if ((nxt == S_STBY) || (nxt == S_ERR)) begin
            stby_n   = 1'b1;
            pbstby_n = 1'b1;
            pcstby_n = 1'b1;
        end
        if (nxt == S_WAIT) begin
            stby_n   = 1'b0;
            pbstby_n = ~sh_pben;
            pcstby_n = ~sh_pcen;
        end
        if (nxt == S_ERR) err_n = 1'b1;
        if (lock_loss) lost_n = 1'b1;
        if (accept) begin
            err_n  = 1'b0;
            lost_n = 1'b0;
        end
    end

    // State, counters, shadow registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cur        <= S_OFF;
            cnt        <= '0;
            tmo        <= '0;
            stl        <= '0;
            rty        <= '0;
            host       <= 1'b0;
            sh_m       <= 1'b0;
            sh_n       <= '0;
            sh_pa      <= '0;
            sh_pb      <= '0;
            sh_pc      <= '0;
            sh_pben    <= 1'b0;
            sh_pcen    <= 1'b0;
            cfg_ack    <= 1'b0;
            pll_stby   <= 1'b1;
            pll_pbstby <= 1'b1;
            pll_pcstby <= 1'b1;
            pll_m      <= 1'b0;
            pll_n      <= '0;
            pll_pa     <= '0;
            pll_pb     <= '0;
            pll_pc     <= '0;
            clk_sel    <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
            lost_lock  <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_n;
            tmo        <= tmo_n;
            stl        <= stl_n;
            rty        <= rty_n;
            host       <= host_n;
            cfg_ack    <= ack_n;
            pll_stby   <= stby_n;
            pll_pbstby <= pbstby_n;
            pll_pcstby <= pcstby_n;
            clk_sel    <= sel_n;
            ready      <= sel_n;
            err        <= err_n;
            lost_lock  <= lost_n;
            if (accept) begin
                sh_m    <= cfg_m;
                sh_n    <= cfg_n;
                sh_pa   <= cfg_pa;
                sh_pb   <= cfg_pb;
                sh_pc   <= cfg_pc;
                sh_pben <= cfg_pben;
                sh_pcen <= cfg_pcen;
            end
            if (load_div) begin
                pll_m  <= sh_m;
                pll_n  <= sh_n;
                pll_pa <= sh_pa;
                pll_pb <= sh_pb;
                pll_pc <= sh_pc;
            end
        end
    end
endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

Sequencing controller for the ABPLSSCH PLL macro. It accepts a divider configuration from a register interface and applies it safely: it parks the core clock on the bypass reference, holds the PLL in standby while the dividers change, then waits for lock with a timeout and retries. Only after lock is stable does it switch the core clock back to the PLL. It runs on the PLL reference clock and sits between the system config registers and the PLL/clock-mux cells.

## Interface
Parameters:
- SW_CYC, 4: cycles held in bypass before standby is asserted.
- STBY_CYC, 8: cycles standby is held with new dividers applied; must be ≥2.
- LOCK_TMO, 1024: cycles allowed in WAIT for synchronized lock.
- SETTLE_CYC, 16: cycles of continuous lock required before switching to the PLL.
- RETRY, 3: extra lock attempts before declaring an error.

Ports:
- clk  in  1  reference clock; the same net as PLL RCLK.
- reset_l  in  1  synchronous, active-low reset.
- cfg_req  in  1  configuration request, level. Held until cfg_ack.
- cfg_m  in  1  M divider (M0).
- cfg_n  in  4  N divider.
- cfg_pa, cfg_pb, cfg_pc  in  4 each  port A/B/C dividers.
- cfg_pben, cfg_pcen  in  1 each  enable port B/C outputs.
- cfg_ack  out  1  one-cycle pulse when a request completes (locked or error).
- pll_stby  out  1  to STBY.
- pll_pbstby, pll_pcstby  out  1 each  to PBSTBY/PCSTBY.
- pll_m  out  1, pll_n/pll_pa/pll_pb/pll_pc  out  4 each  to the divider pins.
- pll_lock  in  1  PLOCK, asynchronous to logic. Passes through a 2-flop synchronizer to give lock_s.
- clk_sel  out  1  core clock mux select: 1 = PLL CLKOA, 0 = bypass reference.
- ready  out  1  PLL is driving the core clock.
- err  out  1  sticky: lock failed after all retries.
- lost_lock  out  1  sticky: lock dropped while in ON.
- state  out  3  debug encoding. OFF=0, BYP=1, STBY=2, WAIT=3, SETL=4, ON=5, ERR=6.

## Operation
- **Reset values:** state OFF, pll_stby=1, pll_pbstby=1, pll_pcstby=1, all dividers 0, clk_sel=0, ready=0, cfg_ack=0, err=0, lost_lock=0, all counters 0. Reset applied in any state returns to these values on the next edge. The FSM never auto-starts from OFF.
- **Request acceptance:** a request is accepted only in OFF, ON or ERR. When accepted:
  - capture all cfg_* inputs into shadow registers;
  - clear err, lost_lock and retry_cnt;
  - go to BYP.
  - In other states cfg_req is left pending; no ack is given.
- **BYP:** clk_sel=0, ready=0. After SW_CYC cycles, go to STBY.
- **STBY:** pll_stby=1, pbstby=1, pcstby=1. Dividers are driven from the shadow registers starting with the first STBY cycle. After STBY_CYC cycles, go to WAIT.
- **WAIT:** pll_stby=0; pbstby=~pben and pcstby=~pcen from the shadows. The timeout counter increments every cycle.
  - lock_s=1: go to SETL.
  - Counter reaches LOCK_TMO with lock_s=0:
    - if retry_cnt<RETRY: increment retry_cnt, clear the counter, go to STBY;
    - otherwise go to ERR.
- **SETL:** counts cycles of lock_s=1.
  - lock_s=0: return to WAIT. The settle count is cleared; the timeout count continues.
  - Settle count reaches SETTLE_CYC: go to ON.
- **ON:** clk_sel=1, ready=1, with cfg_ack pulsed on entry only if entered from a host request.
  - lock_s=0: clk_sel=0 and ready=0 on the next edge, lost_lock=1, retry_cnt=0, go to STBY (automatic relock, no ack).
  - Lock loss and cfg_req in the same cycle: lock loss wins; the request stays pending.
- **ERR:** pll_stby=1, clk_sel=0, err=1, cfg_ack pulsed on entry. Dividers hold their values.
- Dividers never change outside STBY, and never while pll_stby=0.
- lock_s=1 observed in BYP or STBY is ignored.

## Timing
- All outputs are registered.
- Request accepted at edge 0: BYP at edge 1; STBY with dividers valid at edge 1+SW_CYC; pll_stby falls at edge 1+SW_CYC+STBY_CYC.
- PLL lock is visible in lock_s 2 cycles after pll_lock rises.
- clk_sel=1 and cfg_ack occur SETTLE_CYC cycles after the first lock_s=1 cycle in SETL.
- Minimum request-to-ack with defaults is 1+4+8+L+2+16 cycles, where L is the PLL lock delay after stby fall.
- Counters are wide enough for their parameter plus 1 and never wrap.

## Test plan
- **Basic configure:** reset, then cfg_req with M=1, N=0, PA=1. The PLL model locks; expect pll_stby=1 for 8 cycles with dividers stable, then cfg_ack, clk_sel=1 and ready=1 at the computed cycle. The PLL model reports no divider-change error.
- **Timeout with retry:** hold pll_lock=0 after request. Expect 4 WAIT timeouts of 1024 cycles each, separated by STBY re-entries, then ERR with err=1, one cfg_ack and clk_sel=0.
- **Recovery from ERR:** new cfg_req in ERR clears err, and the sequence completes normally.
- **Lock glitch in SETL:** drop pll_lock for 3 cycles at settle count 10. Expect a return to WAIT, then a full 16 settle cycles after relock before clk_sel=1.
- **Loss of lock in ON:** drop pll_lock. Expect clk_sel=0 two cycles plus one edge later, lost_lock=1, automatic relock, ready=1 again, and no cfg_ack.
- **Reset mid-sequence:** apply reset_l=0 in WAIT. Next edge: pll_stby=1, clk_sel=0, dividers 0, state OFF. A pending cfg_req is ignored until reset_l=1.
